// File: rtl/blt_bus_responder.sv
// Bus-side responder for the SC1 blitter: halts the 6809, grants the bus on
// an E-clock boundary, and services blitter RAM reads/writes with wait states.
module blt_bus_responder #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_sync,
    input  logic        cpu_ba,
    output logic        cpu_halt,
    input  logic        halt,
    output logic        halt_ack,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] blt_address_out,
    input  logic [7:0]  blt_data_out,
    input  logic        en_upper,
    input  logic        en_lower,
    output logic        blt_ack,
    output logic [7:0]  blt_data_in,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data_out,
    output logic [1:0]  mem_nibble_we,
    output logic        mem_oe,
    input  logic [7:0]  mem_data_in
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_GRANT   = 3'd2,
        ST_ACCESS  = 3'd3,
        ST_ACK     = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(WAIT_STATES);

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [15:0] addr_r, addr_s;
    logic [7:0]  data_r, data_s;
    logic [1:0]  mask_r, mask_s;
    logic        wr_r, wr_s;
    logic [7:0]  rdata_s;
    logic        cpu_halt_s, halt_ack_s, blt_ack_s, mem_oe_s;
    logic [1:0]  nibble_we_s;
    logic [15:0] mem_address_s;
    logic [7:0]  mem_data_out_s;

    // Next state, request latching on entry to ACCESS, read-data capture
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        data_s  = data_r;
        mask_s  = mask_r;
        wr_s    = wr_r;
        rdata_s = blt_data_in;
        case (state_r)
            ST_IDLE: begin
                if (halt) state_s = ST_REQ;
                else      state_s = ST_IDLE;
            end
            ST_REQ: begin
                if (!halt)                 state_s = ST_RELEASE;
                else if (e_sync && cpu_ba) state_s = ST_GRANT;
                else                       state_s = ST_REQ;
            end
            ST_GRANT: begin
                if (read || write) begin
                    state_s = ST_ACCESS;
                    cnt_s   = 3'd0;
                    addr_s  = blt_address_out;
                    data_s  = blt_data_out;
                    mask_s  = {en_upper, en_lower};
                    wr_s    = write;
                end else if (!halt) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_GRANT;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == LAST_CNT) begin
                    state_s = ST_ACK;
                    cnt_s   = 3'd0;
                    if (!wr_r) rdata_s = mem_data_in;
                    else       rdata_s = blt_data_in;
                end else begin
                    state_s = ST_ACCESS;
                    cnt_s   = cnt_r + 3'd1;
                end
            end
            ST_ACK: begin
                if (halt) state_s = ST_GRANT;
                else      state_s = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Bus must be back with the CPU before a new halt is accepted
                if (!cpu_ba) state_s = ST_IDLE;
                else         state_s = ST_RELEASE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so every output leaves a flop
    always_comb begin
        cpu_halt_s     = 1'b0;
        halt_ack_s     = 1'b0;
        blt_ack_s      = 1'b0;
        mem_oe_s       = 1'b0;
        nibble_we_s    = 2'b00;
        mem_address_s  = 16'h0000;
        mem_data_out_s = 8'h00;
        case (state_s)
            ST_REQ: begin
                cpu_halt_s = 1'b1;
            end
            ST_GRANT: begin
                cpu_halt_s = 1'b1;
                halt_ack_s = 1'b1;
            end
            ST_ACCESS: begin
                cpu_halt_s    = 1'b1;
                halt_ack_s    = 1'b1;
                mem_address_s = addr_s;
                if (wr_s) begin
                    nibble_we_s    = mask_s;
                    mem_data_out_s = data_s;
                end else begin
                    mem_oe_s = 1'b1;
                end
            end
            ST_ACK: begin
                cpu_halt_s = 1'b1;
                halt_ack_s = 1'b1;
                blt_ack_s  = 1'b1;
            end
            default: begin
                cpu_halt_s = 1'b0;
            end
        endcase
    end

    // State, access latches and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 3'd0;
            addr_r        <= 16'h0000;
            data_r        <= 8'h00;
            mask_r        <= 2'b00;
            wr_r          <= 1'b0;
            cpu_halt      <= 1'b0;
            halt_ack      <= 1'b0;
            blt_ack       <= 1'b0;
            blt_data_in   <= 8'h00;
            mem_address   <= 16'h0000;
            mem_data_out  <= 8'h00;
            mem_nibble_we <= 2'b00;
            mem_oe        <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            addr_r        <= addr_s;
            data_r        <= data_s;
            mask_r        <= mask_s;
            wr_r          <= wr_s;
            cpu_halt      <= cpu_halt_s;
            halt_ack      <= halt_ack_s;
            blt_ack       <= blt_ack_s;
            blt_data_in   <= rdata_s;
            mem_address   <= mem_address_s;
            mem_data_out  <= mem_data_out_s;
            mem_nibble_we <= nibble_we_s;
            mem_oe        <= mem_oe_s;
        end
    end

endmodule

// File: tb/tb_blt_bus_responder.sv
// Directed plus randomized bench for blt_bus_responder; expectations come
// from a transaction-level memory model and the handshake timing rules.
module tb_blt_bus_responder;

    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        reset, e_sync, cpu_ba, halt, read, write, en_upper, en_lower;
    logic [15:0] blt_address_out;
    logic [7:0]  blt_data_out;
    logic        cpu_halt, halt_ack, blt_ack, mem_oe;
    logic [7:0]  blt_data_in, mem_data_out, mem_data_in;
    logic [15:0] mem_address;
    logic [1:0]  mem_nibble_we;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  last_read;
    logic [7:0]  exp_ram [logic [15:0]];
    logic [15:0] pool [0:7];

    blt_bus_responder #(.WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .e_sync(e_sync), .cpu_ba(cpu_ba),
        .cpu_halt(cpu_halt), .halt(halt), .halt_ack(halt_ack),
        .read(read), .write(write), .blt_address_out(blt_address_out),
        .blt_data_out(blt_data_out), .en_upper(en_upper), .en_lower(en_lower),
        .blt_ack(blt_ack), .blt_data_in(blt_data_in), .mem_address(mem_address),
        .mem_data_out(mem_data_out), .mem_nibble_we(mem_nibble_we),
        .mem_oe(mem_oe), .mem_data_in(mem_data_in)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_get(input logic [15:0] a);
        if (!exp_ram.exists(a)) exp_ram[a] = 8'($urandom);
        return exp_ram[a];
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_cpu_halt"}, 32'(cpu_halt), 32'd0);
        chk({tag, "_halt_ack"}, 32'(halt_ack), 32'd0);
        chk({tag, "_blt_ack"}, 32'(blt_ack), 32'd0);
        chk({tag, "_mem_oe"}, 32'(mem_oe), 32'd0);
        chk({tag, "_we"}, 32'(mem_nibble_we), 32'd0);
        chk({tag, "_rdata"}, 32'(blt_data_in), 32'd0);
        chk({tag, "_addr"}, 32'(mem_address), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_data_out), 32'd0);
    endtask

    // From IDLE: raise halt and expect the grant one cycle after the first e_sync with cpu_ba
    task automatic grant_phase(input int ba_start, input int es_first, input int es_period);
        int g;
        g = es_first;
        while (g < ba_start) g += es_period;
        chk("idle_cpu_halt", 32'(cpu_halt), 32'd0);
        halt = 1'b1;
        cpu_ba = (ba_start <= 0);
        e_sync = 1'b0;
        for (int c = 1; c <= g + 1; c++) begin
            tick();
            chk("req_cpu_halt", 32'(cpu_halt), 32'd1);
            chk("grant_align", 32'(halt_ack), 32'(c > g));
            cpu_ba = (c >= ba_start);
            e_sync = (c >= es_first) && (((c - es_first) % es_period) == 0);
        end
        e_sync = 1'b0;
    endtask

    // Issue one request from GRANT; returns in the ACK cycle
    task automatic do_access(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [7:0] d, input logic [1:0] m, input int drop_k);
        logic [7:0] rv;
        logic [7:0] old;
        rv = 8'h00;
        if (!wr) rv = mem_get(a);
        read = rd;
        write = wr;
        blt_address_out = a;
        blt_data_out = d;
        {en_upper, en_lower} = m;
        mem_data_in = ~rv;
        for (int k = 1; k <= WS + 2; k++) begin
            tick();
            chk("acc_halt_ack", 32'(halt_ack), 32'd1);
            if (k <= WS + 1) begin
                chk("acc_blt_ack", 32'(blt_ack), 32'd0);
                chk("acc_mem_oe", 32'(mem_oe), 32'(!wr));
                chk("acc_we", 32'(mem_nibble_we), 32'(wr ? m : 2'b00));
                chk("acc_addr", 32'(mem_address), 32'(a));
                if (wr) chk("acc_wdata", 32'(mem_data_out), 32'(d));
                blt_address_out = 16'($urandom);
                blt_data_out = 8'($urandom);
                {en_upper, en_lower} = 2'($urandom);
                mem_data_in = (k == WS + 1) ? rv : ~rv;
            end else begin
                chk("ack_pulse", 32'(blt_ack), 32'd1);
                chk("ack_mem_oe", 32'(mem_oe), 32'd0);
                chk("ack_we", 32'(mem_nibble_we), 32'd0);
                if (wr) begin
                    chk("ack_rdata_hold", 32'(blt_data_in), 32'(last_read));
                    old = mem_get(a);
                    exp_ram[a] = {m[1] ? d[7:4] : old[7:4], m[0] ? d[3:0] : old[3:0]};
                end else begin
                    chk("ack_rdata", 32'(blt_data_in), 32'(rv));
                    last_read = rv;
                end
                read = 1'b0;
                write = 1'b0;
            end
            if (k == drop_k) halt = 1'b0;
        end
    endtask

    task automatic after_ack_grant();
        tick();
        chk("post_ack_single", 32'(blt_ack), 32'd0);
        chk("post_ack_grant", 32'(halt_ack), 32'd1);
        chk("post_ack_rdata", 32'(blt_data_in), 32'(last_read));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, gap;
        logic [7:0] old;
        reset = 1'b1; e_sync = 1'b0; cpu_ba = 1'b0; halt = 1'b0;
        read = 1'b0; write = 1'b0; en_upper = 1'b0; en_lower = 1'b0;
        blt_address_out = 16'h0000; blt_data_out = 8'h00; mem_data_in = 8'h00;
        last_read = 8'h00;
        for (int i = 0; i < 8; i++) pool[i] = 16'($urandom);
        pool[0] = 16'h1122;
        pool[1] = 16'h3344;
        exp_ram[16'h1122] = 8'h69;

        repeat (2) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Grant alignment from the test plan
        grant_phase(3, 8, 12);

        // Read, then the three nibble-mask writes, then read back
        do_access(1'b1, 1'b0, 16'h1122, 8'h00, 2'b00, 0);
        chk("read_0x69", 32'(blt_data_in), 32'h69);
        after_ack_grant();
        old = mem_get(16'h3344);
        do_access(1'b0, 1'b1, 16'h3344, 8'hA5, 2'b10, 0);
        after_ack_grant();
        do_access(1'b0, 1'b1, 16'h3344, 8'hA5, 2'b11, 0);
        after_ack_grant();
        do_access(1'b0, 1'b1, 16'h3344, 8'hA5, 2'b00, 0);
        after_ack_grant();
        do_access(1'b1, 1'b0, 16'h3344, 8'h00, 2'b00, 0);
        chk("readback_3344", 32'(blt_data_in), 32'hA5);
        after_ack_grant();

        // Simultaneous read and write performs a write
        do_access(1'b1, 1'b1, pool[2], 8'h3C, 2'b11, 0);
        after_ack_grant();
        do_access(1'b1, 1'b0, pool[2], 8'h00, 2'b00, 0);
        chk("rw_write_won", 32'(blt_data_in), 32'h3C);
        after_ack_grant();

        // Randomized traffic with idle GRANT gaps
        for (int t = 0; t < 24; t++) begin
            gap = $urandom_range(0, 2);
            for (int i = 0; i < gap; i++) begin
                tick();
                chk("gap_grant", 32'(halt_ack), 32'd1);
                chk("gap_no_ack", 32'(blt_ack), 32'd0);
                chk("gap_no_oe", 32'(mem_oe), 32'd0);
            end
            op = $urandom_range(0, 2);
            do_access(op != 1, op != 0, pool[$urandom_range(0, 7)], 8'($urandom),
                      2'($urandom), 0);
            after_ack_grant();
        end

        // Release handshake: halt drops mid-access
        do_access(1'b0, 1'b1, pool[3], 8'h5A, 2'b01, 1);
        tick();
        chk("rel_halt_ack", 32'(halt_ack), 32'd0);
        chk("rel_cpu_halt", 32'(cpu_halt), 32'd0);
        chk("rel_blt_ack", 32'(blt_ack), 32'd0);
        halt = 1'b1;
        cpu_ba = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rel_ignore_halt", 32'(cpu_halt), 32'd0);
            chk("rel_no_grant", 32'(halt_ack), 32'd0);
        end
        cpu_ba = 1'b0;
        tick();
        chk("rel_idle", 32'(cpu_halt), 32'd0);
        tick();
        chk("rel_new_req", 32'(cpu_halt), 32'd1);
        chk("rel_new_noack", 32'(halt_ack), 32'd0);
        cpu_ba = 1'b1;
        e_sync = 1'b1;
        tick();
        e_sync = 1'b0;
        chk("rel_regrant", 32'(halt_ack), 32'd1);

        // Asynchronous reset in the middle of a write
        write = 1'b1;
        blt_address_out = pool[4];
        blt_data_out = 8'hFF;
        {en_upper, en_lower} = 2'b11;
        tick();
        chk("mid_we", 32'(mem_nibble_we), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        write = 1'b0;
        halt = 1'b0;
        cpu_ba = 1'b0;
        last_read = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        tick();
        grant_phase($urandom_range(1, 10), $urandom_range(1, 6), $urandom_range(2, 12));
        do_access(1'b1, 1'b0, pool[5], 8'h00, 2'b00, 0);
        after_ack_grant();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
